rv32_fetch_unit: RTL and testbench
==================================

# rv32_fetch_unit

Instruction-fetch stage of the RV32 pipeline, directly upstream of the IF/ID queue. It owns the fetch PC and issues word requests on a valid/grant instruction-memory port. Returned words go into a 2-entry fetch buffer, whose head drives the IF/ID queue's `code_in`/`pc_in`. It applies branch redirects and the 3-cycle load-to-use PC freeze, and generates the `load_to_use_stall_ff3` timing that the queue's skid buffer consumes.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `FB_DEPTH`, 2, fetch-buffer entries; fixed at 2 in this revision.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  downstream stall; the buffer head is not consumed.
- `load_to_use_stall`  in  1  hazard pulse from the hazard unit.
- `redirect_valid`  in  1  taken branch/jump/exception redirect.
- `redirect_pc`  in  32  redirect target; bits [1:0] are forced to 0.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request word address; equals `fetch_pc`.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; arrives at least 1 cycle after `imem_gnt`.
- `imem_rdata`  in  32  response instruction.
- `fetch_valid`  out  1  buffer head is valid.
- `code_out`  out  32  head instruction; 0 (bubble) when empty.
- `pc_out`  out  32  head PC; 0 when empty.
- `load_to_use_stall_ff3`  out  1  `load_to_use_stall` delayed by 3 clocks.

## Operation
- FSM states:
  - REQ: `imem_req` = !redirect_valid && freeze_cnt==0 && (count < FB_DEPTH). On `imem_gnt`: `fetch_pc` += 4 and go to WAIT.
  - WAIT: `imem_req`=0. On `imem_rvalid`: push {pc_of_req, imem_rdata} and go to REQ. If `redirect_valid` occurs before `imem_rvalid`: go to DROP.
  - DROP: `imem_req`=0. On `imem_rvalid`: discard the data and go to REQ. A further redirect in DROP only updates `fetch_pc`.
- At most one request is outstanding. The space check counts the outstanding slot, so a push can never overflow.
- Pop: fetch_valid && !stall && freeze_cnt==0 && !redirect_valid.
- Push and pop in the same cycle are both allowed; count is unchanged.
- Redirect takes priority over everything else:
  - `fetch_pc` ← {redirect_pc[31:2],2'b00}.
  - Buffer count ← 0.
  - An `imem_rvalid` arriving in the same cycle as the redirect is dropped.
- Freeze: `load_to_use_stall`=1 loads `freeze_cnt` ← 3. Otherwise `freeze_cnt` decrements while nonzero. A new pulse during a freeze reloads it to 3.
- While frozen:
  - no new requests are issued and no pops occur;
  - an in-flight response is still pushed.
- `load_to_use_stall_ff3`: 3-stage shift register of `load_to_use_stall`, cleared by `rst`. Redirect does not clear it.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values (asserted at the edge with `rst`=1):
  - `fetch_pc`=RESET_PC, FSM=REQ, count=0, freeze_cnt=0, shift register=0.
  - Outputs: `imem_req`=0 while `rst`=1; `fetch_valid`=0, `code_out`=0, `pc_out`=0, `load_to_use_stall_ff3`=0.
- First `imem_req`=1 is in the first cycle with `rst`=0.
- Fetch latency: gnt in cycle N, rvalid in cycle N+k (k≥1). The entry is visible on the outputs in cycle N+k+1; the outputs are registered from the buffer with no bypass.
- Redirect in cycle N:
  - `fetch_valid`=0 in N+1.
  - `imem_req` with `imem_addr`=target in N+1, provided no response is pending.
- Reset during WAIT/DROP returns the FSM to REQ. A late `imem_rvalid` arriving after reset is ignored while the FSM is in REQ.

## Structure
- Shared package `rv32_pkg`:
  - `fetch_state_e` {REQ, WAIT, DROP};
  - `fb_entry_t` {pc[31:0], code[31:0]};
  - constant `NOP_CODE`=32'h0;
  - constant `L2U_FREEZE_CYCLES`=3.
- One sub-module: `rv32_fetch_buffer`, a 2-entry circular FIFO with push, pop, flush, count, head.

## Test plan
- Reset with RESET_PC=32'h100, zero-wait memory (gnt same cycle, rvalid next) → `pc_out` sequence 0x100, 0x104, 0x108 on consecutive valid cycles.
- `stall`=1 for 5 cycles with continuous responses:
  - buffer holds 2 entries and `imem_req` drops to 0;
  - on release, the sequence continues with no PC lost or duplicated.
- Redirect to 32'h2000 while in WAIT:
  - the old response is discarded (DROP);
  - the next `pc_out` is 0x2000 with its `imem_rdata`.
- `load_to_use_stall` pulse in cycle N:
  - no `imem_req` and no pop in N+1..N+3;
  - `load_to_use_stall_ff3`=1 in N+3;
  - fetch resumes in N+4.
- `fetch_pc`=32'hFFFF_FFFC → next request address is 32'h0.
- `rst` asserted in WAIT with `imem_rvalid` arriving one cycle later → the response is ignored and the buffer stays empty.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 fetch stage.
package rv32_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] code;
  } fb_entry_t;

  localparam logic [31:0] NOP_CODE = 32'h0;
  localparam logic [1:0]  L2U_FREEZE_CYCLES = 2'd3;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32_fetch_unit_if.sv
// Instruction-memory request/response port of the fetch stage.
interface rv32_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/rv32_fetch_buffer.sv
// 2-entry circular FIFO holding fetched {pc, code} pairs.
module rv32_fetch_buffer
  import rv32_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fb_entry_t  din,
  output logic [1:0] count,
  output fb_entry_t  head
);

  fb_entry_t mem [2];
  logic      rd_ptr;
  logic      wr_ptr;
  logic      do_push;
  logic      do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rv32_fetch_unit.sv
// RV32 fetch stage: PC owner, single-outstanding imem requests,
// redirect flush, load-to-use freeze and its 3-cycle delayed pulse.
module rv32_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FB_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               load_to_use_stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  rv32_fetch_unit_if.master  imem,
  output logic               fetch_valid,
  output logic [31:0]        code_out,
  output logic [31:0]        pc_out,
  output logic               load_to_use_stall_ff3
);

  fetch_state_e state;
  fetch_state_e state_n;
  logic [31:0]  fetch_pc;
  logic [31:0]  req_pc;
  logic [1:0]   freeze_cnt;
  logic [2:0]   l2u_sr;
  logic [1:0]   fb_count;
  fb_entry_t    fb_head;
  logic         req;
  logic         push;
  logic         pop;
  logic         frozen;
  logic         has_space;
  logic         granted;

  assign frozen    = freeze_cnt != 2'd0;
  assign has_space = int'(fb_count) < FB_DEPTH;
  assign granted   = req && imem.imem_gnt;
  assign pop       = fetch_valid && !stall
                   && !frozen && !redirect_valid;

  always_comb begin
    state_n = state;
    req     = 1'b0;
    push    = 1'b0;
    unique case (state)
      REQ: begin
        req = !rst && !redirect_valid
            && !frozen && has_space;
        if (req && imem.imem_gnt) state_n = WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          push    = !redirect_valid;
          state_n = REQ;
        end else if (redirect_valid) begin
          state_n = DROP;
        end
      end
      DROP: begin
        if (imem.imem_rvalid) state_n = REQ;
      end
      default: state_n = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      freeze_cnt <= 2'd0;
      l2u_sr     <= 3'b000;
    end else begin
      state  <= state_n;
      l2u_sr <= {l2u_sr[1:0], load_to_use_stall};
      if (granted) req_pc <= fetch_pc;
      if (redirect_valid)
        fetch_pc <= word_align(redirect_pc);
      else if (granted)
        fetch_pc <= fetch_pc + 32'd4;
      // a new hazard pulse restarts the full freeze window
      if (load_to_use_stall)
        freeze_cnt <= L2U_FREEZE_CYCLES;
      else if (frozen)
        freeze_cnt <= freeze_cnt - 2'd1;
    end
  end

  rv32_fetch_buffer u_fb (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ('{pc: req_pc, code: imem.imem_rdata}),
    .count (fb_count),
    .head  (fb_head)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc;

  assign fetch_valid = fb_count != 2'd0;
  assign code_out    = fetch_valid ? fb_head.code : NOP_CODE;
  assign pc_out      = fetch_valid ? fb_head.pc : 32'h0;
  assign load_to_use_stall_ff3 = l2u_sr[2];

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Self-checking bench for rv32_fetch_unit: transaction-level model,
// randomized memory/hazard stimulus and directed scenarios.
module tb_rv32_fetch_unit;
  import rv32_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, l2u, redir;
  logic [31:0] rpc;
  logic        fetch_valid, ff3;
  logic [31:0] code_out, pc_out;

  always #5 clk = ~clk;

  rv32_fetch_unit_if imem ();

  rv32_fetch_unit #(.RESET_PC(RPC), .FB_DEPTH(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .stall                 (stall),
    .load_to_use_stall     (l2u),
    .redirect_valid        (redir),
    .redirect_pc           (rpc),
    .imem                  (imem),
    .fetch_valid           (fetch_valid),
    .code_out              (code_out),
    .pc_out                (pc_out),
    .load_to_use_stall_ff3 (ff3)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  logic        d_rst, d_stall, d_l2u, d_redir;
  logic [31:0] d_rpc;

  logic [31:0] m_pc;
  fb_entry_t   m_q[$];
  int          m_frz;
  logic        m_pend, m_drop;
  logic [31:0] m_pend_pc;
  logic [2:0]  m_hist;

  logic        mem_busy;
  int          mem_wait;
  logic [31:0] mem_pc;
  int          gnt_pct, dmin, dmax;
  logic [31:0] salt;

  logic        e_req, e_valid, e_ff3;
  logic [31:0] e_addr, e_code, e_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic mem_update();
    if (imem.imem_rvalid) mem_busy = 1'b0;
    if (imem.imem_gnt) begin
      mem_busy = 1'b1;
      mem_wait = $urandom_range(dmax, dmin) - 1;
      mem_pc   = m_pc;
    end
  endtask

  task automatic model_update();
    logic g, pp;
    if (rst) begin
      m_pc = RPC;
      m_q.delete();
      m_frz = 0;
      m_pend = 1'b0;
      m_drop = 1'b0;
      m_hist = 3'b000;
    end else begin
      g  = e_req && imem.imem_gnt;
      pp = (m_q.size() > 0) && !stall && (m_frz == 0) && !redir;
      if (pp) void'(m_q.pop_front());
      if (m_pend && imem.imem_rvalid) begin
        if (!m_drop && !redir)
          m_q.push_back('{pc: m_pend_pc, code: imem.imem_rdata});
        m_pend = 1'b0;
      end
      if (g) begin
        m_pend = 1'b1;
        m_drop = 1'b0;
        m_pend_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
      if (redir) begin
        m_pc = {rpc[31:2], 2'b00};
        m_q.delete();
        if (m_pend) m_drop = 1'b1;
      end
      m_frz  = l2u ? 3 : (m_frz > 0 ? m_frz - 1 : 0);
      m_hist = {m_hist[1:0], l2u};
    end
  endtask

  task automatic drive();
    rst   = d_rst;
    stall = d_stall;
    l2u   = d_l2u;
    redir = d_redir;
    rpc   = d_rpc;
    e_req = !rst && !redir && (m_frz == 0)
          && !m_pend && (m_q.size() < 2);
    e_addr  = m_pc;
    e_valid = m_q.size() > 0;
    e_code  = 32'h0;
    e_pc    = 32'h0;
    if (e_valid) begin
      e_code = m_q[0].code;
      e_pc   = m_q[0].pc;
    end
    e_ff3 = m_hist[2];
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = $urandom;
    if (mem_busy) begin
      if (mem_wait == 0) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = word_of(mem_pc);
      end else begin
        mem_wait--;
      end
    end
    imem.imem_gnt = e_req && !mem_busy
                  && ($urandom_range(99, 0) < gnt_pct);
  endtask

  task automatic tick();
    @(posedge clk);
    mem_update();
    model_update();
    #1;
    drive();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", imem.imem_req, e_req);
      if (e_req) check("imem_addr", imem.imem_addr, e_addr);
      check("fetch_valid", fetch_valid, e_valid);
      check("code_out", code_out, e_code);
      check("pc_out", pc_out, e_pc);
      check("ff3", ff3, e_ff3);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic [31:0] p0, g_pc;
    salt = $urandom;
    d_rst = 1'b1; d_stall = 1'b0; d_l2u = 1'b0;
    d_redir = 1'b0; d_rpc = 32'h0;
    rst = 1'b1; stall = 1'b0; l2u = 1'b0;
    redir = 1'b0; rpc = 32'h0;
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = 32'h0;
    mem_busy = 1'b0; mem_wait = 0; mem_pc = 32'h0;
    gnt_pct = 100; dmin = 1; dmax = 1;
    m_pc = RPC; m_frz = 0; m_pend = 1'b0;
    m_drop = 1'b0; m_hist = 3'b000; m_pend_pc = 32'h0;
    e_req = 1'b0; e_valid = 1'b0; e_ff3 = 1'b0;
    e_addr = 32'h0; e_code = 32'h0; e_pc = 32'h0;

    tick();
    chk_en = 1'b1;
    tick();
    check("rst_req", imem.imem_req, 1'b0);
    check("rst_valid", fetch_valid, 1'b0);
    check("rst_code", code_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_ff3", ff3, 1'b0);

    // zero-wait memory straight out of reset
    d_rst = 1'b0;
    tick();
    check("first_req", imem.imem_req, 1'b1);
    check("first_addr", imem.imem_addr, 32'h100);
    idx = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      tick();
      if (fetch_valid) begin
        check("zw_pc", pc_out, 32'h100 + 32'(4 * idx));
        if (idx == 0)
          check("zw_code", code_out, word_of(32'h100));
        idx++;
      end
    end
    check("zw_seen", idx, 3);

    // downstream stall fills the buffer
    d_stall = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("stall_req", imem.imem_req, 1'b0);
    check("stall_valid", fetch_valid, 1'b1);
    p0 = e_pc;
    d_stall = 1'b0;
    tick();
    check("rel0_valid", fetch_valid, 1'b1);
    check("rel0_pc", pc_out, p0);
    tick();
    check("rel1_valid", fetch_valid, 1'b1);
    check("rel1_pc", pc_out, p0 + 32'd4);
    idx = 0;
    for (int c = 0; c < 10 && idx == 0; c++) begin
      tick();
      if (fetch_valid) begin
        check("rel2_pc", pc_out, p0 + 32'd8);
        idx = 1;
      end
    end
    check("rel2_seen", idx, 1);

    // redirect while a slow response is in flight
    dmin = 3; dmax = 3;
    idx = 0;
    for (int c = 0; c < 20 && idx == 0; c++) begin
      tick();
      if (imem.imem_gnt) idx = 1;
    end
    check("redir_gnt_seen", idx, 1);
    d_redir = 1'b1; d_rpc = 32'h0000_2001;
    tick();
    d_redir = 1'b0;
    tick();
    check("redir_flush", fetch_valid, 1'b0);
    idx = 0;
    for (int c = 0; c < 20 && idx == 0; c++) begin
      tick();
      if (imem.imem_req) begin
        check("redir_addr", imem.imem_addr, 32'h2000);
        idx = 1;
      end
    end
    check("redir_req_seen", idx, 1);
    idx = 0;
    for (int c = 0; c < 20 && idx == 0; c++) begin
      tick();
      if (fetch_valid) begin
        check("redir_pc", pc_out, 32'h2000);
        check("redir_code", code_out, word_of(32'h2000));
        idx = 1;
      end
    end
    check("redir_valid_seen", idx, 1);

    // load-to-use freeze window
    dmin = 1; dmax = 1;
    for (int c = 0; c < 10; c++) tick();
    idx = 0;
    for (int c = 0; c < 10 && idx == 0; c++) begin
      tick();
      if (imem.imem_rvalid) idx = 1;
    end
    check("l2u_sync", idx, 1);
    d_l2u = 1'b1;
    tick();
    check("l2u_n_req", imem.imem_req, 1'b1);
    g_pc = e_addr;
    d_l2u = 1'b0;
    tick();
    check("l2u_n1_req", imem.imem_req, 1'b0);
    tick();
    check("l2u_n2_req", imem.imem_req, 1'b0);
    check("l2u_n2_pc", pc_out, g_pc);
    tick();
    check("l2u_n3_req", imem.imem_req, 1'b0);
    check("l2u_n3_pc", pc_out, g_pc);
    check("l2u_n3_ff3", ff3, 1'b1);
    tick();
    check("l2u_n4_req", imem.imem_req, 1'b1);

    // PC wraps modulo 2^32
    d_redir = 1'b1; d_rpc = 32'hFFFF_FFFC;
    tick();
    d_redir = 1'b0;
    idx = 0;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      tick();
      if (imem.imem_req) begin
        check("wrap_addr", imem.imem_addr,
              idx == 0 ? 32'hFFFF_FFFC : 32'h0);
        idx++;
      end
    end
    check("wrap_seen", idx, 2);

    // reset while waiting; the late response must be ignored
    dmin = 2; dmax = 2;
    idx = 0;
    for (int c = 0; c < 20 && idx == 0; c++) begin
      tick();
      if (imem.imem_gnt) idx = 1;
    end
    check("rstw_gnt_seen", idx, 1);
    d_rst = 1'b1;
    tick();
    d_rst = 1'b0;
    tick();
    check("rstw_stale_rv", imem.imem_rvalid, 1'b1);
    check("rstw_valid0", fetch_valid, 1'b0);
    check("rstw_addr0", imem.imem_addr, RPC);
    tick();
    check("rstw_valid1", fetch_valid, 1'b0);
    check("rstw_addr1", imem.imem_addr, RPC);

    // randomized traffic against the model
    gnt_pct = 70; dmin = 1; dmax = 3;
    for (int c = 0; c < 3000; c++) begin
      d_stall = $urandom_range(99, 0) < 30;
      d_l2u   = $urandom_range(99, 0) < 4;
      d_redir = $urandom_range(99, 0) < 4;
      d_rpc   = ($urandom_range(9, 0) == 0)
              ? 32'hFFFF_FFF0 | 32'($urandom_range(15, 0))
              : $urandom;
      d_rst   = $urandom_range(999, 0) < 3;
      tick();
    end
    d_stall = 1'b0; d_l2u = 1'b0;
    d_redir = 1'b0; d_rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
